// File: rtl/sector_cache_pkg.sv
// Shared configuration, address-field layout and per-way state for the sector-cache model.
`default_nettype none

package sector_cache_pkg;

    localparam int DEF_ADDR_W         = 31;
    localparam int DEF_CACHE_BYTES    = 32768;
    localparam int DEF_SECTOR_BYTES   = 256;
    localparam int DEF_SUBBLOCK_BYTES = 64;
    localparam int DEF_ASSOC          = 4;

    localparam int SUBBLOCKS = DEF_SECTOR_BYTES / DEF_SUBBLOCK_BYTES;
    localparam int SETS      = DEF_CACHE_BYTES / (DEF_SECTOR_BYTES * DEF_ASSOC);

    // *_BITS may be zero for degenerate geometries; *_W is the storage width (never zero).
    localparam int OFF_W    = $clog2(DEF_SUBBLOCK_BYTES);
    localparam int SUB_BITS = $clog2(SUBBLOCKS);
    localparam int SET_BITS = $clog2(SETS);
    localparam int SUB_W    = (SUB_BITS > 0) ? SUB_BITS : 1;
    localparam int SET_W    = (SET_BITS > 0) ? SET_BITS : 1;
    localparam int TAG_W    = DEF_ADDR_W - OFF_W - SUB_BITS - SET_BITS;
    localparam int AGE_W    = (DEF_ASSOC > 1) ? $clog2(DEF_ASSOC) : 1;
    localparam int WAY_W    = AGE_W;

    typedef struct packed {
        logic [TAG_W-1:0]     tag;
        logic                 tag_valid;
        logic [SUBBLOCKS-1:0] sub_valid;
        logic [AGE_W-1:0]     age;
    } way_entry_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [SET_W-1:0] set;
        logic [SUB_W-1:0] sub;
    } addr_fields_t;

    function automatic addr_fields_t split_addr(input logic [DEF_ADDR_W-1:0] addr);
        addr_fields_t          f;
        logic [DEF_ADDR_W-1:0] sh;
        sh    = addr >> OFF_W;
        f.sub = SUB_W'(sh) & SUB_W'(SUBBLOCKS - 1);
        sh    = sh >> SUB_BITS;
        f.set = SET_W'(sh) & SET_W'(SETS - 1);
        sh    = sh >> SET_BITS;
        f.tag = TAG_W'(sh);
        return f;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sector_cache_lru.sv
// Age-based LRU for one set: next-age vector for a touched way, plus the oldest way as victim.
`default_nettype none

module sector_cache_lru
    import sector_cache_pkg::*;
#(
    parameter int WAYS     = DEF_ASSOC,
    parameter int AGE_BITS = AGE_W,
    parameter int IDX_BITS = WAY_W
) (
    input  logic [WAYS-1:0][AGE_BITS-1:0] ages,
    input  logic [IDX_BITS-1:0]           touch,
    output logic [WAYS-1:0][AGE_BITS-1:0] ages_next,
    output logic [IDX_BITS-1:0]           victim
);

    always_comb begin
        victim = '0;
        for (int w = 1; w < WAYS; w++) begin
            if (ages[w] > ages[victim]) victim = IDX_BITS'(w);
        end
    end

    // Ways younger than the touched one age by one; the touched way becomes MRU.
    always_comb begin
        ages_next = ages;
        for (int w = 0; w < WAYS; w++) begin
            if (IDX_BITS'(w) == touch)
                ages_next[w] = '0;
            else if (ages[w] < ages[touch])
                ages_next[w] = ages[w] + AGE_BITS'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/test.sv
// Trace-driven sector-cache hit/miss model: one access per clock, saturating hit and miss counters.
`default_nettype none

module test
    import sector_cache_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int CACHE_BYTES    = DEF_CACHE_BYTES,
    parameter int SECTOR_BYTES   = DEF_SECTOR_BYTES,
    parameter int SUBBLOCK_BYTES = DEF_SUBBLOCK_BYTES,
    parameter int ASSOC          = DEF_ASSOC
) (
    input  logic [ADDR_W-1:0] adder_41,
    input  logic              clk_41,
    input  logic              rst_41,
    output logic [ADDR_W-1:0] misses_41,
    output logic [ADDR_W-1:0] hits_41
);

    localparam int N_SETS = CACHE_BYTES / (SECTOR_BYTES * ASSOC);
    localparam int N_SUB  = SECTOR_BYTES / SUBBLOCK_BYTES;

    way_entry_t cache [N_SETS][ASSOC];

    addr_fields_t                   fields;
    logic [ASSOC-1:0][AGE_W-1:0]    ages;
    logic [ASSOC-1:0][AGE_W-1:0]    ages_next;
    logic                           match_any;
    logic                           free_any;
    logic                           sub_hit;
    logic [WAY_W-1:0]               match_way;
    logic [WAY_W-1:0]               free_way;
    logic [WAY_W-1:0]               lru_way;
    logic [WAY_W-1:0]               touch;

    assign fields = split_addr(adder_41);

    // Scan downward so the lowest-index match / free way wins.
    always_comb begin
        ages      = '0;
        match_any = 1'b0;
        match_way = '0;
        free_any  = 1'b0;
        free_way  = '0;
        for (int w = ASSOC - 1; w >= 0; w--) begin
            ages[w] = cache[fields.set][w].age;
            if (cache[fields.set][w].tag_valid && cache[fields.set][w].tag == fields.tag) begin
                match_any = 1'b1;
                match_way = WAY_W'(w);
            end
            if (!cache[fields.set][w].tag_valid) begin
                free_any = 1'b1;
                free_way = WAY_W'(w);
            end
        end
    end

    assign sub_hit = match_any && cache[fields.set][match_way].sub_valid[fields.sub];
    assign touch   = match_any ? match_way : (free_any ? free_way : lru_way);

    sector_cache_lru #(
        .WAYS     (ASSOC),
        .AGE_BITS (AGE_W),
        .IDX_BITS (WAY_W)
    ) u_lru (
        .ages      (ages),
        .touch     (touch),
        .ages_next (ages_next),
        .victim    (lru_way)
    );

    always_ff @(posedge clk_41) begin
        if (rst_41) begin
            for (int s = 0; s < N_SETS; s++) begin
                for (int w = 0; w < ASSOC; w++) begin
                    cache[s][w] <= '{tag: '0, tag_valid: 1'b0, sub_valid: '0, age: AGE_W'(w)};
                end
            end
            hits_41   <= '0;
            misses_41 <= '0;
        end else begin
            for (int w = 0; w < ASSOC; w++) begin
                cache[fields.set][w].age <= ages_next[w];
            end
            if (!match_any) begin
                cache[fields.set][touch].tag       <= fields.tag;
                cache[fields.set][touch].tag_valid <= 1'b1;
                cache[fields.set][touch].sub_valid <= N_SUB'(1) << fields.sub;
            end else begin
                cache[fields.set][touch].sub_valid[fields.sub] <= 1'b1;
            end
            if (sub_hit) begin
                if (~&hits_41) hits_41 <= hits_41 + ADDR_W'(1);
            end else begin
                if (~&misses_41) misses_41 <= misses_41 + ADDR_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_test.sv
// Directed bench for the sector-cache model: each task checks cumulative miss/hit counts after every access.
`default_nettype none

module tb_test;

    logic        clk = 1'b0;
    logic        rst;
    logic [30:0] adder;
    logic [30:0] misses;
    logic [30:0] hits;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    test dut (
        .adder_41  (adder),
        .clk_41    (clk),
        .rst_41    (rst),
        .misses_41 (misses),
        .hits_41   (hits)
    );

    task automatic apply_reset(input int n);
        rst   = 1'b1;
        adder = 31'h0000_0140;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic access(input int a);
        adder = 31'(a);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        adder = 31'h0000_2000;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (misses !== 31'd0 || hits !== 31'd0) begin
                miscompares++;
                $display("FAIL reset[%0d] misses=%0d hits=%0d expected misses=0 hits=0", i, misses, hits);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_repeat;
        int em [2] = '{1, 1};
        int eh [2] = '{0, 1};
        apply_reset(1);
        for (int i = 0; i < 2; i++) begin
            access(0);
            vectors++;
            if (misses !== 31'(em[i]) || hits !== 31'(eh[i])) begin
                miscompares++;
                $display("FAIL repeat[%0d] misses=%0d hits=%0d expected misses=%0d hits=%0d",
                         i, misses, hits, em[i], eh[i]);
            end
        end
    endtask

    task automatic test_subblock;
        int a  [5] = '{0, 32, 64, 0, 64};
        int em [5] = '{1, 1, 2, 2, 2};
        int eh [5] = '{0, 1, 1, 2, 3};
        apply_reset(1);
        for (int i = 0; i < 5; i++) begin
            access(a[i]);
            vectors++;
            if (misses !== 31'(em[i]) || hits !== 31'(eh[i])) begin
                miscompares++;
                $display("FAIL subblock[%0d] addr=%0d misses=%0d hits=%0d expected misses=%0d hits=%0d",
                         i, a[i], misses, hits, em[i], eh[i]);
            end
        end
    endtask

    task automatic test_conflict;
        int a  [7] = '{0, 8192, 16384, 24576, 32768, 8192, 0};
        int em [7] = '{1, 2, 3, 4, 5, 5, 6};
        int eh [7] = '{0, 0, 0, 0, 0, 1, 1};
        apply_reset(1);
        for (int i = 0; i < 7; i++) begin
            access(a[i]);
            vectors++;
            if (misses !== 31'(em[i]) || hits !== 31'(eh[i])) begin
                miscompares++;
                $display("FAIL conflict[%0d] addr=%0d misses=%0d hits=%0d expected misses=%0d hits=%0d",
                         i, a[i], misses, hits, em[i], eh[i]);
            end
        end
    endtask

    task automatic test_refill;
        int a [7] = '{0, 64, 8192, 16384, 24576, 32768, 64};
        apply_reset(1);
        for (int i = 0; i < 7; i++) begin
            access(a[i]);
            vectors++;
            if (misses !== 31'(i + 1) || hits !== 31'd0) begin
                miscompares++;
                $display("FAIL refill[%0d] addr=%0d misses=%0d hits=%0d expected misses=%0d hits=0",
                         i, a[i], misses, hits, i + 1);
            end
        end
    endtask

    // A hit on way 0 must make it MRU so the next fill evicts way 1 instead.
    task automatic test_lru_touch;
        int a  [8] = '{0, 8192, 16384, 24576, 0, 32768, 0, 8192};
        int em [8] = '{1, 2, 3, 4, 4, 5, 5, 6};
        int eh [8] = '{0, 0, 0, 0, 1, 1, 2, 2};
        apply_reset(1);
        for (int i = 0; i < 8; i++) begin
            access(a[i]);
            vectors++;
            if (misses !== 31'(em[i]) || hits !== 31'(eh[i])) begin
                miscompares++;
                $display("FAIL lru_touch[%0d] addr=%0d misses=%0d hits=%0d expected misses=%0d hits=%0d",
                         i, a[i], misses, hits, em[i], eh[i]);
            end
        end
    endtask

    // Same tag in different sets must not alias.
    task automatic test_sets;
        int a  [4] = '{0, 256, 7936, 256};
        int em [4] = '{1, 2, 3, 3};
        int eh [4] = '{0, 0, 0, 1};
        apply_reset(1);
        for (int i = 0; i < 4; i++) begin
            access(a[i]);
            vectors++;
            if (misses !== 31'(em[i]) || hits !== 31'(eh[i])) begin
                miscompares++;
                $display("FAIL sets[%0d] addr=%0d misses=%0d hits=%0d expected misses=%0d hits=%0d",
                         i, a[i], misses, hits, em[i], eh[i]);
            end
        end
    endtask

    task automatic test_midreset;
        apply_reset(1);
        access(0);
        access(0);
        vectors++;
        if (misses !== 31'd1 || hits !== 31'd1) begin
            miscompares++;
            $display("FAIL midreset_pre misses=%0d hits=%0d expected misses=1 hits=1", misses, hits);
        end
        rst   = 1'b1;
        adder = 31'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if (misses !== 31'd0 || hits !== 31'd0) begin
            miscompares++;
            $display("FAIL midreset_clear misses=%0d hits=%0d expected misses=0 hits=0", misses, hits);
        end
        access(0);
        vectors++;
        if (misses !== 31'd1 || hits !== 31'd0) begin
            miscompares++;
            $display("FAIL midreset_post misses=%0d hits=%0d expected misses=1 hits=0", misses, hits);
        end
    endtask

    initial begin
        rst   = 1'b1;
        adder = 31'd0;
        test_reset();
        test_repeat();
        test_subblock();
        test_conflict();
        test_refill();
        test_lru_touch();
        test_sets();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
